// File: rtl/dsp_share_arbiter.sv
// -----------------------------------------------------------------------------
// dsp_share_arbiter
//
// Shares one DSP slice between up to NREQ calculation engines. The engines
// use a req/grant handshake. A granted requester keeps the DSP for as long as
// it holds its req. After each release there is one dead cycle, and the next
// owner is then picked round-robin. A grant shift register tags every DSP
// result with the requester that issued the operands, so that results are
// routed correctly across pipeline latency and ownership hand-over.
//
// Parameters:
//   NREQ      number of requesters (2..8)
//   DSP_IN_W  width of one flattened DSP input bus (opmode, a, b)
//   PIPE_LAT  cycles from operands on dsp_ins_flat to the matching result
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   req           per-requester ownership request (level)
//   req_ins_flat  requester i drives slice [i*DSP_IN_W +: DSP_IN_W]
//   grant         registered one-hot (or zero) ownership grant
//   dsp_ins_flat  owner's operand slice to the DSP, all zeros when idle
//   busy          registered, 1 while any grant is active
//   owner_id      registered index of the current owner, 0 when idle
//   res_tag       one-hot owner of the DSP result in this cycle
// -----------------------------------------------------------------------------
module dsp_share_arbiter #(
  parameter int NREQ     = 3,
  parameter int DSP_IN_W = 44,
  parameter int PIPE_LAT = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DSP_IN_W-1:0] req_ins_flat,
  output logic [NREQ-1:0]          grant,
  output logic [DSP_IN_W-1:0]      dsp_ins_flat,
  output logic                     busy,
  output logic [2:0]               owner_id,
  output logic [NREQ-1:0]          res_tag
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWNED = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]          state_r;
  logic [1:0]          state_n_s;
  logic [2:0]          ptr_r;
  logic [2:0]          ptr_n_s;
  logic [NREQ-1:0]     grant_r;
  logic [NREQ-1:0]     grant_n_s;
  logic [2:0]          owner_r;
  logic [2:0]          owner_n_s;
  logic                busy_r;
  logic                busy_n_s;
  logic [NREQ-1:0]     tag_pipe_r [PIPE_LAT];

  // req is zero-extended to 8 bits so that a 3-bit index always fits exactly
  logic [7:0]          req_ext_s;
  logic                win_valid_s;
  logic [2:0]          win_idx_s;
  logic [7:0]          win_oh_s;
  logic [2:0]          owner_next_ptr_s;
  logic [DSP_IN_W-1:0] mux_s;

  // Zero-extend the request vector for fixed-width indexing
  always_comb begin
    req_ext_s = 8'd0;
    req_ext_s[NREQ-1:0] = req;
  end

  // Round-robin search: the first set req at or after ptr_r, with wrap at NREQ
  always_comb begin
    logic [3:0] sum_v;
    win_valid_s = 1'b0;
    win_idx_s   = 3'd0;
    sum_v       = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr_r < NREQ <= 8, so the sum stays below 16 and a single wrap is enough
      sum_v = {1'b0, ptr_r} + 4'(k);
      if (sum_v >= 4'(NREQ)) begin
        sum_v = sum_v - 4'(NREQ);
      end else begin
        sum_v = sum_v;
      end
      if (!win_valid_s && req_ext_s[sum_v[2:0]]) begin
        win_valid_s = 1'b1;
        win_idx_s   = sum_v[2:0];
      end else begin
        win_valid_s = win_valid_s;
      end
    end
  end

  // One-hot form of the winner, and the pointer position after the current owner
  always_comb begin
    win_oh_s = 8'd1 << win_idx_s;
    if (owner_r == 3'(NREQ - 1)) begin
      owner_next_ptr_s = 3'd0;
    end else begin
      owner_next_ptr_s = owner_r + 3'd1;
    end
  end

  // Next-state logic for the ownership FSM
  always_comb begin
    state_n_s = state_r;
    ptr_n_s   = ptr_r;
    grant_n_s = grant_r;
    owner_n_s = owner_r;
    busy_n_s  = busy_r;
    case (state_r)
      ST_IDLE, ST_GAP: begin
        if (win_valid_s) begin
          state_n_s = ST_OWNED;
          grant_n_s = win_oh_s[NREQ-1:0];
          owner_n_s = win_idx_s;
          busy_n_s  = 1'b1;
        end else begin
          state_n_s = ST_IDLE;
          grant_n_s = '0;
          owner_n_s = 3'd0;
          busy_n_s  = 1'b0;
        end
      end
      ST_OWNED: begin
        // No preemption: only the owner's own req decides the release
        if (req_ext_s[owner_r]) begin
          state_n_s = ST_OWNED;
        end else begin
          state_n_s = ST_GAP;
          grant_n_s = '0;
          owner_n_s = 3'd0;
          busy_n_s  = 1'b0;
          ptr_n_s   = owner_next_ptr_s;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        ptr_n_s   = 3'd0;
        grant_n_s = '0;
        owner_n_s = 3'd0;
        busy_n_s  = 1'b0;
      end
    endcase
  end

  // Ownership state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= 3'd0;
      grant_r <= '0;
      owner_r <= 3'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      ptr_r   <= ptr_n_s;
      grant_r <= grant_n_s;
      owner_r <= owner_n_s;
      busy_r  <= busy_n_s;
    end
  end

  // Result-tag shift register. It keeps shifting while idle, so in-flight
  // results still carry the tag of the requester that issued them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < PIPE_LAT; s++) begin
        tag_pipe_r[s] <= '0;
      end
    end else begin
      tag_pipe_r[0] <= grant_r;
      for (int s = 1; s < PIPE_LAT; s++) begin
        tag_pipe_r[s] <= tag_pipe_r[s-1];
      end
    end
  end

  // AND-OR operand mux driven only by the one-hot grant register, so the
  // output is zero (DSP opmode idle) whenever there is no grant
  always_comb begin
    mux_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      mux_s = mux_s | (req_ins_flat[i*DSP_IN_W +: DSP_IN_W] & {DSP_IN_W{grant_r[i]}});
    end
  end

  assign grant        = grant_r;
  assign busy         = busy_r;
  assign owner_id     = owner_r;
  assign res_tag      = tag_pipe_r[PIPE_LAT-1];
  assign dsp_ins_flat = mux_s;

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dsp_share_arbiter
//
// Directed bench for dsp_share_arbiter with NREQ=3, DSP_IN_W=44, PIPE_LAT=2.
// Each step drives req, waits one clock edge, and checks grant, busy,
// owner_id and dsp_ins_flat against the expected grant for that step.
// Expected grants are pushed onto a tag queue and popped PIPE_LAT cycles
// later for comparison with res_tag.
// -----------------------------------------------------------------------------
module tb_dsp_share_arbiter;

  localparam int NREQ     = 3;
  localparam int DSP_IN_W = 44;
  localparam int PIPE_LAT = 2;

  logic                     clk;
  logic                     reset_n;
  logic [NREQ-1:0]          req;
  logic [NREQ*DSP_IN_W-1:0] req_ins_flat;
  logic [NREQ-1:0]          grant;
  logic [DSP_IN_W-1:0]      dsp_ins_flat;
  logic                     busy;
  logic [2:0]               owner_id;
  logic [NREQ-1:0]          res_tag;

  logic [DSP_IN_W-1:0]      ins [NREQ];
  logic [NREQ-1:0]          tag_q [$];
  int                       n_tests;
  int                       n_fail;

  dsp_share_arbiter #(
    .NREQ     (NREQ),
    .DSP_IN_W (DSP_IN_W),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_ins_flat (req_ins_flat),
    .grant        (grant),
    .dsp_ins_flat (dsp_ins_flat),
    .busy         (busy),
    .owner_id     (owner_id),
    .res_tag      (res_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic new_data();
    for (int i = 0; i < NREQ; i++) begin
      ins[i] = DSP_IN_W'({$urandom, $urandom});
      req_ins_flat[i*DSP_IN_W +: DSP_IN_W] = ins[i];
    end
  endtask

  task automatic reset_tags();
    tag_q.delete();
    for (int i = 0; i < PIPE_LAT; i++) tag_q.push_back('0);
  endtask

  // Drive req, take one edge, then compare every output against eg
  task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] eg);
    logic [2:0]          idx;
    logic [DSP_IN_W-1:0] exp_d;
    logic [NREQ-1:0]     exp_t;
    req = r;
    @(posedge clk);
    #1;
    idx   = 3'd0;
    exp_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (eg[i]) begin
        idx   = 3'(i);
        exp_d = ins[i];
      end
    end
    check("grant",    64'(grant),        64'(eg));
    check("busy",     64'(busy),         64'(|eg));
    check("owner_id", 64'(owner_id),     64'(idx));
    check("dsp_ins",  64'(dsp_ins_flat), 64'(exp_d));
    exp_t = tag_q.pop_front();
    check("res_tag",  64'(res_tag),      64'(exp_t));
    tag_q.push_back(eg);
    new_data();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    req     = '0;
    new_data();
    reset_tags();

    // Reset state
    #12;
    check("rst_grant",   64'(grant),        64'd0);
    check("rst_busy",    64'(busy),         64'd0);
    check("rst_owner",   64'(owner_id),     64'd0);
    check("rst_res_tag", 64'(res_tag),      64'd0);
    check("rst_dsp",     64'(dsp_ins_flat), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single requester 2, then release into GAP and IDLE
    for (int i = 0; i < 3; i++) cyc(3'b000, 3'b000);
    for (int i = 0; i < 4; i++) cyc(3'b100, 3'b100);
    cyc(3'b000, 3'b000);
    for (int i = 0; i < 3; i++) cyc(3'b000, 3'b000);

    // Simultaneous start (pointer back at 0), then rotation 0,1,2,0 with a
    // gap between owners; the released owner re-raises immediately
    for (int o = 0; o < 4; o++) begin
      logic [NREQ-1:0] eg;
      eg = 3'b001 << (o % NREQ);
      for (int c = 0; c < 4; c++) cyc(3'b111, eg);
      cyc(3'b111 & ~eg, 3'b000);
    end
    cyc(3'b000, 3'b000);
    for (int i = 0; i < 3; i++) cyc(3'b000, 3'b000);

    // Lost pulse: req[2] pulses for one cycle while owner 0 holds
    cyc(3'b001, 3'b001);
    cyc(3'b101, 3'b001);
    cyc(3'b001, 3'b001);
    cyc(3'b001, 3'b001);
    cyc(3'b000, 3'b000);
    for (int i = 0; i < 4; i++) cyc(3'b000, 3'b000);

    // Lock: owner 0 holds for 1000 cycles while req[1] waits
    cyc(3'b001, 3'b001);
    for (int i = 0; i < 1000; i++) cyc(3'b011, 3'b001);
    cyc(3'b010, 3'b000);
    cyc(3'b010, 3'b010);
    cyc(3'b000, 3'b000);
    for (int i = 0; i < 3; i++) cyc(3'b000, 3'b000);

    // Reset mid-ownership: owner 1 holds with req=011
    cyc(3'b010, 3'b010);
    cyc(3'b011, 3'b010);
    cyc(3'b011, 3'b010);
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_grant",   64'(grant),        64'd0);
    check("mid_rst_busy",    64'(busy),         64'd0);
    check("mid_rst_owner",   64'(owner_id),     64'd0);
    check("mid_rst_res_tag", 64'(res_tag),      64'd0);
    check("mid_rst_dsp",     64'(dsp_ins_flat), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    reset_tags();
    cyc(3'b011, 3'b001);
    cyc(3'b010, 3'b000);
    cyc(3'b010, 3'b010);
    cyc(3'b000, 3'b000);
    for (int i = 0; i < 3; i++) cyc(3'b000, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
